// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore FSM controller for the shared-memory multi-cycle MIPS datapath.
// Each instruction steps through FETCH / DECODE / execute / memory / write-back
// states. The controller waits on mem_ready in FETCH, MEMREAD and MEMWRITE.
// The datapath controls are kept in a look-ahead register: they are decoded
// from the next state, so the flops always hold the decode of the current
// state. mem_ready and reset are then applied combinationally on top, because
// the FETCH strobes, the MEMWRITE completion pulse and the reset blanking
// must all act in the same cycle.
// STATE_W must be at least 4 so that TRAP (12) fits in the state register.

module multicycle_control_unit #(
  parameter int ENABLE_JUMP = 1,
  parameter int ENABLE_ADDI = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  // Opcodes from instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU B input selects
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation selects
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEMADDR   = STATE_W'(2),
    S_MEMREAD   = STATE_W'(3),
    S_MEMWB     = STATE_W'(4),
    S_MEMWRITE  = STATE_W'(5),
    S_EXEC      = STATE_W'(6),
    S_RWB       = STATE_W'(7),
    S_BRANCH    = STATE_W'(8),
    S_JUMP      = STATE_W'(9),
    S_ADDI_EXEC = STATE_W'(10),
    S_ADDI_WB   = STATE_W'(11),
    S_TRAP      = STATE_W'(12)
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctl_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] op_q;
  ctl_t       ctl_q;
  ctl_t       ctl;

  // Moore decode of the datapath controls for one state. FETCH's PC/IR loads
  // are set here unconditionally and qualified by mem_ready at the output.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
        c.pc_write  = 1'b1;
        c.ir_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCS_JUMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_TRAP: begin
        c.illegal_op = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state function. DECODE branches on the live opcode (the same value
  // being captured into op_q). Every later decision uses op_q.
  function automatic state_t next_state_f(input state_t     s,
                                          input logic [5:0] op_live,
                                          input logic [5:0] op_reg,
                                          input logic       ready);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_live)
          OP_LW, OP_SW: n = S_MEMADDR;
          OP_RTYPE:     n = S_EXEC;
          OP_BEQ:       n = S_BRANCH;
          OP_J:         n = (ENABLE_JUMP != 0) ? S_JUMP : S_TRAP;
          OP_ADDI:      n = (ENABLE_ADDI != 0) ? S_ADDI_EXEC : S_TRAP;
          default:      n = S_TRAP;
        endcase
      end
      S_MEMADDR:   n = (op_reg == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   n = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:  n = ready ? S_FETCH : S_MEMWRITE;
      S_EXEC:      n = S_RWB;
      S_ADDI_EXEC: n = S_ADDI_WB;
      default:     n = S_FETCH;
    endcase
    return n;
  endfunction

  // Next-state selection from the current state, opcode and memory handshake
  always_comb begin
    state_nxt = next_state_f(state, opcode, op_q, mem_ready);
  end

  // State register, opcode capture and look-ahead registered control word
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
      ctl_q <= decode_ctl(S_FETCH);
    end else begin
      state <= state_nxt;
      ctl_q <= decode_ctl(state_nxt);
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Apply the mem_ready qualifiers and reset blanking to the registered controls
  // NOTE: ctl takes a full default first so no path through this block infers a latch.
  always_comb begin
    ctl = ctl_q;
    if (state == S_FETCH) begin
      ctl.pc_write = ctl_q.pc_write & mem_ready;
      ctl.ir_write = ctl_q.ir_write & mem_ready;
    end
    if (state == S_MEMWRITE) begin
      ctl.instr_done = mem_ready;
    end
    if (reset) begin
      ctl = '0;
    end
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemToReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign illegal_op  = ctl.illegal_op;
  assign instr_done  = ctl.instr_done;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Scoreboard bench for the multi-cycle controller. Two instances share their
// inputs: dut_a uses the default parameters, and dut_b has ENABLE_JUMP=0.
// The stimulus pushes one entry per clock into a queue. Each entry holds the
// hand-derived state for each instance plus the inputs of that cycle. A
// monitor pops on the falling edge and compares state_dbg and the full
// control word against the expected table.

module tb_multicycle_control_unit;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, ill_a, done_a;
  logic [1:0] asb_a, aop_a, pcs_a;
  logic [3:0] st_a;
  logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, ill_b, done_b;
  logic [1:0] asb_b, aop_b, pcs_b;
  logic [3:0] st_b;

  multicycle_control_unit dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .IRWrite(irw_a), .MemToReg(m2r_a), .RegDst(rdst_a),
    .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(aop_a),
    .PCSource(pcs_a), .illegal_op(ill_a), .instr_done(done_a), .state_dbg(st_a)
  );

  multicycle_control_unit #(.ENABLE_JUMP(0), .ENABLE_ADDI(1), .STATE_W(4)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b),
    .MemWrite(mwr_b), .IRWrite(irw_b), .MemToReg(m2r_b), .RegDst(rdst_b),
    .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
    .PCSource(pcs_b), .illegal_op(ill_b), .instr_done(done_b), .state_dbg(st_b)
  );

  logic [17:0] act_a, act_b;
  assign act_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a,
                  asb_a, aop_a, pcs_a, ill_a, done_a};
  assign act_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b,
                  asb_b, aop_b, pcs_b, ill_b, done_b};

  typedef struct {
    int    sa;
    int    sb;
    bit    mr;
    bit    rst;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected control word for a state, written from the controller's state table.
  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst
  // RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] illegal_op instr_done
  function automatic logic [17:0] exp_ctl(input int s, input bit mr, input bit rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, done;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, done} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!rst) begin
      case (s)
        0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
        1:  begin asb = 2'b11; end
        2:  begin asa = 1; asb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin m2r = 1; rw = 1; done = 1; end
        5:  begin mwr = 1; iord = 1; done = mr; end
        6:  begin asa = 1; aop = 2'b10; end
        7:  begin rdst = 1; rw = 1; done = 1; end
        8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
        9:  begin pcw = 1; pcs = 2'b10; done = 1; end
        10: begin asa = 1; asb = 2'b10; end
        11: begin rw = 1; done = 1; end
        12: begin ill = 1; done = 1; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, done};
  endfunction

  // Drive one cycle of inputs and queue what both instances must show in it
  task automatic step(input logic [5:0] op, input bit mr, input bit rst,
                      input int sa, input int sb, input string tag);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    reset     = rst;
    e.sa = sa; e.sb = sb; e.mr = mr; e.rst = rst; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per cycle and compare both instances
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, " state_a"}, 32'(st_a),  32'(e.sa));
      check({e.tag, " ctl_a"},   32'(act_a), 32'(exp_ctl(e.sa, e.mr, e.rst)));
      check({e.tag, " state_b"}, 32'(st_b),  32'(e.sb));
      check({e.tag, " ctl_b"},   32'(act_b), 32'(exp_ctl(e.sb, e.mr, e.rst)));
    end
  end

  initial begin
    int wait_cycles;
    reset     = 1'b1;
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset state: register already at FETCH, all controls blanked
    step(OP_RTYPE, 1, 1, 0, 0, "reset");

    // lw with memory always ready: 0,1,2,3,4
    step(OP_LW, 1, 0, 0, 0, "lw");
    step(OP_LW, 1, 0, 1, 1, "lw");
    step(OP_LW, 1, 0, 2, 2, "lw");
    step(OP_LW, 1, 0, 3, 3, "lw");
    step(OP_LW, 1, 0, 4, 4, "lw");

    // sw: mem_ready low in DECODE/MEMADDR (ignored) and 3 cycles in MEMWRITE
    step(OP_SW, 1, 0, 0, 0, "sw");
    step(OP_SW, 0, 0, 1, 1, "sw");
    step(OP_SW, 0, 0, 2, 2, "sw");
    step(OP_SW, 0, 0, 5, 5, "sw_wait");
    step(OP_SW, 0, 0, 5, 5, "sw_wait");
    step(OP_SW, 0, 0, 5, 5, "sw_wait");
    step(OP_SW, 1, 0, 5, 5, "sw_exit");

    // R-type then beq back to back
    step(OP_RTYPE, 1, 0, 0, 0, "rtype");
    step(OP_RTYPE, 1, 0, 1, 1, "rtype");
    step(OP_RTYPE, 1, 0, 6, 6, "rtype");
    step(OP_RTYPE, 1, 0, 7, 7, "rtype");
    step(OP_BEQ,   1, 0, 0, 0, "beq");
    step(OP_BEQ,   1, 0, 1, 1, "beq");
    step(OP_BEQ,   1, 0, 8, 8, "beq");

    // j: decoded on dut_a, trapped on dut_b
    step(OP_J, 1, 0, 0, 0,  "jump");
    step(OP_J, 1, 0, 1, 1,  "jump");
    step(OP_J, 1, 0, 9, 12, "jump");

    // addi with opcode switched to beq after DECODE
    step(OP_ADDI, 1, 0, 0, 0,   "addi");
    step(OP_ADDI, 1, 0, 1, 1,   "addi");
    step(OP_BEQ,  1, 0, 10, 10, "addi_chg");
    step(OP_BEQ,  1, 0, 11, 11, "addi_chg");

    // unsupported opcode
    step(OP_BAD, 1, 0, 0, 0,   "illegal");
    step(OP_BAD, 1, 0, 1, 1,   "illegal");
    step(OP_BAD, 1, 0, 12, 12, "illegal");

    // lw with fetch stall, then reset during the MEMREAD wait
    step(OP_LW, 0, 0, 0, 0, "fetch_stall");
    step(OP_LW, 0, 0, 0, 0, "fetch_stall");
    step(OP_LW, 1, 0, 0, 0, "lw2");
    step(OP_LW, 1, 0, 1, 1, "lw2");
    step(OP_LW, 1, 0, 2, 2, "lw2");
    step(OP_LW, 0, 0, 3, 3, "memread_wait");
    step(OP_LW, 0, 0, 3, 3, "memread_wait");
    step(OP_LW, 0, 1, 3, 3, "mid_reset");
    step(OP_LW, 1, 0, 0, 0, "after_reset");
    step(OP_LW, 1, 0, 1, 1, "lw3");
    step(OP_LW, 1, 0, 2, 2, "lw3");
    step(OP_LW, 1, 0, 3, 3, "lw3");
    step(OP_LW, 1, 0, 4, 4, "lw3");
    step(OP_RTYPE, 0, 0, 0, 0, "final_fetch");

    // let the monitor drain the queue, bounded
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
